fetcher: RTL and testbench

Instruction fetch stage of the minigpu core. Sits directly downstream of the `pc` block: latches `next_pc`, issues a read to program memory over a request/response handshake, and holds the returned 16-bit instruction stable for the decoder until the control unit advances. Reports its progress to the control unit through `fetch_done` and `fetcher_state`.

---
 rtl/fetcher.sv | 107 ++++++++++
 tb/tb_fetcher.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Instruction fetch stage: latches pc, reads program memory over a
// req/resp handshake and holds the instruction until the control unit
// advances.
// Ports: clk, reset (sync, active-high), cu_state, pc,
//   mem_req_valid/addr/ready, mem_resp_valid/data,
//   instruction, fetch_done, fetcher_state.
// Optional: define FETCHER_REUSE_EN to skip memory on a refetch of the
//   last fetched address (one-entry tag).
module fetcher #(
  parameter int PC_ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               cu_state,
  input  logic [PC_ADDR_WIDTH-1:0] pc,
  output logic                     mem_req_valid,
  output logic [PC_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0]   mem_resp_data,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     fetch_done,
  output logic [1:0]               fetcher_state
);

  localparam logic [3:0] CU_FETCH  = 4'd1;
  localparam logic [3:0] CU_UPDATE = 4'd6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state;
  state_t state_n;
  logic   reuse_hit;
  logic   start;
  logic   capture;

  assign start   = (state == IDLE) && (cu_state == CU_FETCH);
  assign capture = (state == WAIT_RESP) && mem_resp_valid;

`ifdef FETCHER_REUSE_EN
  logic [PC_ADDR_WIDTH-1:0] tag_addr;
  logic                     tag_valid;

  assign reuse_hit = tag_valid && (tag_addr == pc);

  // Tag records the address of every completed memory fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_addr  <= '0;
    end else if (capture) begin
      tag_valid <= 1'b1;
      tag_addr  <= mem_req_addr;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cu_state == CU_FETCH)
          state_n = reuse_hit ? DONE : REQUEST;
      end
      REQUEST: begin
        if (mem_req_ready)
          state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid)
          state_n = DONE;
      end
      DONE: begin
        if (cu_state == CU_UPDATE)
          state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_req_addr <= '0;
      instruction  <= '0;
    end else begin
      state <= state_n;
      // Address is frozen from the start edge until the next fetch.
      if (start)
        mem_req_addr <= pc;
      if (capture)
        instruction <= mem_resp_data;
    end
  end

  assign mem_req_valid = (state == REQUEST);
  assign fetch_done    = (state == DONE);
  assign fetcher_state = state;

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for fetcher.
// Inputs change 1ns after each rising edge; outputs checked there.
module tb_fetcher;

  logic        clk;
  logic        reset;
  logic [3:0]  cu_state;
  logic [7:0]  pc;
  logic        mem_req_valid;
  logic [7:0]  mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic [15:0] instruction;
  logic        fetch_done;
  logic [1:0]  fetcher_state;

  int n_chk;
  int n_pass;

  fetcher dut (
    .clk           (clk),
    .reset         (reset),
    .cu_state      (cu_state),
    .pc            (pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .instruction   (instruction),
    .fetch_done    (fetch_done),
    .fetcher_state (fetcher_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cu_state       = 4'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 16'h0000;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Minimum-latency fetch ending in DONE, then UPDATE back to IDLE.
  task automatic fetch_min(input string tag, input logic [7:0] a,
                           input logic [15:0] d);
    pc = a; cu_state = 4'd1;
    step();
    cu_state = 4'd0;
    chk({tag, "_req"}, mem_req_valid, 1);
    chk({tag, "_addr"}, mem_req_addr, a);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk({tag, "_wait"}, fetcher_state, 2);
    mem_resp_valid = 1'b1; mem_resp_data = d;
    step();
    mem_resp_valid = 1'b0;
    chk({tag, "_done"}, fetch_done, 1);
    chk({tag, "_instr"}, instruction, d);
    cu_state = 4'd6;
    step();
    cu_state = 4'd0;
    chk({tag, "_idle"}, fetcher_state, 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    pc = 8'h00;
    reset = 1'b0;
    idle_in();

    // Reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_req", mem_req_valid, 0);
    end
    chk("rst_state", fetcher_state, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_done", fetch_done, 0);

    // Minimum latency fetch
    pc = 8'h04; cu_state = 4'd1;
    step();                                  // edge N
    cu_state = 4'd0; mem_req_ready = 1'b1;
    chk("t2_req", mem_req_valid, 1);
    chk("t2_addr", mem_req_addr, 8'h04);
    chk("t2_st1", fetcher_state, 1);
    step();                                  // edge N+1
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 16'hA5C3;
    chk("t2_st2", fetcher_state, 2);
    chk("t2_req_drop", mem_req_valid, 0);
    chk("t2_done_early", fetch_done, 0);
    step();                                  // edge N+2
    mem_resp_valid = 1'b0;
    chk("t2_done", fetch_done, 1);
    chk("t2_instr", instruction, 16'hA5C3);
    chk("t2_st3", fetcher_state, 3);
    cu_state = 4'd6;
    step();
    cu_state = 4'd0;
    chk("t2_upd_state", fetcher_state, 0);
    chk("t2_upd_done", fetch_done, 0);
    chk("t2_upd_instr", instruction, 16'hA5C3);

    // Stalled fetch; clear any tag left by the previous fetch of 8'h04
    do_reset();
    pc = 8'h04; cu_state = 4'd1;
    step();                                  // edge N
    cu_state = 4'd0;
    pc = 8'h10;
    for (int i = 0; i < 3; i++) begin
      chk("t3_req_hold", mem_req_valid, 1);
      chk("t3_addr_hold", mem_req_addr, 8'h04);
      step();                                // edges N+1..N+3
    end
    chk("t3_req_hold4", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    step();                                  // edge N+4
    mem_req_ready = 1'b0;
    chk("t3_wait", fetcher_state, 2);
    for (int i = 0; i < 3; i++) begin
      step();                                // edges N+5..N+7
      chk("t3_stall", fetcher_state, 2);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 16'h5A5A;
    step();                                  // edge N+8
    mem_resp_valid = 1'b0;
    chk("t3_done", fetch_done, 1);
    chk("t3_instr", instruction, 16'h5A5A);
    cu_state = 4'd6;
    step();
    cu_state = 4'd0;

    // Spurious responses in IDLE and REQUEST
    mem_resp_valid = 1'b1; mem_resp_data = 16'hFFFF;
    step();
    chk("t4_idle_state", fetcher_state, 0);
    chk("t4_idle_instr", instruction, 16'h5A5A);
    pc = 8'h20; cu_state = 4'd1;
    step();
    cu_state = 4'd0;
    chk("t4_req_state", fetcher_state, 1);
    chk("t4_req_instr", instruction, 16'h5A5A);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk("t4_acc_state", fetcher_state, 2);
    chk("t4_acc_instr", instruction, 16'h5A5A);
    mem_resp_valid = 1'b1; mem_resp_data = 16'h0F0F;
    step();
    mem_resp_valid = 1'b0;
    chk("t4_instr", instruction, 16'h0F0F);
    cu_state = 4'd6;
    step();
    cu_state = 4'd0;

    // Reset in WAIT, late response ignored; reset beats FETCH
    pc = 8'h30; cu_state = 4'd1;
    step();
    cu_state = 4'd0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t5_wait", fetcher_state, 2);
    reset = 1'b1; cu_state = 4'd1;
    step();
    reset = 1'b0; cu_state = 4'd0;
    chk("t5_rst_state", fetcher_state, 0);
    chk("t5_rst_addr", mem_req_addr, 0);
    mem_resp_valid = 1'b1; mem_resp_data = 16'h1234;
    step();
    mem_resp_valid = 1'b0;
    chk("t5_state", fetcher_state, 0);
    chk("t5_instr", instruction, 0);
    chk("t5_done", fetch_done, 0);

    // Refetch of the same address
    fetch_min("t6a", 8'h06, 16'hBEEF);
    pc = 8'h06; cu_state = 4'd1;
    step();
    cu_state = 4'd0;
`ifdef FETCHER_REUSE_EN
    chk("t6_hit_req", mem_req_valid, 0);
    chk("t6_hit_done", fetch_done, 1);
    chk("t6_hit_instr", instruction, 16'hBEEF);
`else
    chk("t6_miss_req", mem_req_valid, 1);
    chk("t6_miss_addr", mem_req_addr, 8'h06);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 16'hBEEF;
    step();
    mem_resp_valid = 1'b0;
    chk("t6_miss_done", fetch_done, 1);
    chk("t6_miss_instr", instruction, 16'hBEEF);
`endif
    cu_state = 4'd6;
    step();
    cu_state = 4'd0;
    chk("t6_idle", fetcher_state, 0);
    fetch_min("t6b", 8'h08, 16'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
